census_window_ctrl: RTL and testbench

//  Sequences the tapped shift-register window feeding the census transform.

---
 rtl/census_window_ctrl.sv | 87 ++++++++
 tb/tb_census_window_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/census_window_ctrl.sv
// census_window_ctrl: raster window sequencer driving the census window FIFOs
module census_window_ctrl #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 48,
  parameter int WIN        = 5,
  parameter int CW         = $clog2(IMG_WIDTH),
  parameter int RW         = $clog2(IMG_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_sof,
  output logic          in_ready,
  output logic          shift_en,
  output logic          fifo_clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] win_col,
  output logic [RW-1:0] win_row,
  output logic          frame_done,
  output logic          frame_err
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  localparam logic [CW-1:0] CMAX = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] RMAX = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] CMIN = CW'(WIN - 1);
  localparam logic [RW-1:0] RMIN = RW'(WIN - 1);
  state_t state;
  logic [CW-1:0] col, pc;
  logic [RW-1:0] row, pr;
  logic accept, win_hit;
  // the taps hold the presented window, so nothing enters until it is consumed
  assign in_ready = rst & (state != FLUSH) & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign shift_en = accept & (state == RUN | in_sof);
  assign pc       = in_sof ? '0 : col;
  assign pr       = in_sof ? '0 : row;
  assign win_hit  = shift_en & (pc >= CMIN) & (pr >= RMIN);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      out_valid  <= 1'b0;
      win_col    <= '0;
      win_row    <= '0;
      fifo_clr   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err  <= accept & in_sof & (state == RUN);
      fifo_clr   <= 1'b0;
      frame_done <= 1'b0;
      if (win_hit) begin
        out_valid <= 1'b1;
        win_col   <= pc;
        win_row   <= pr;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: if (shift_en) begin
          col   <= CW'(1);
          row   <= '0;
          state <= RUN;
        end
        RUN: if (shift_en) begin
          if (in_sof) begin
            col <= CW'(1);
            row <= '0;
          end else if (col == CMAX) begin
            col <= '0;
            row <= (row == RMAX) ? '0 : row + 1'b1;
            if (row == RMAX) begin
              state      <= FLUSH;
              fifo_clr   <= 1'b1;
              frame_done <= 1'b1;
            end
          end else begin
            col <= col + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_census_window_ctrl.sv
// tb_census_window_ctrl: vector table, directed corner cases and random traffic vs. a pixel-index model
module tb_census_window_ctrl;
  localparam int W = 8, H = 6, K = 3;
  logic clk = 0, rst = 0, in_valid = 0, in_sof = 0, out_ready = 0;
  logic in_ready, shift_en, fifo_clr, out_valid, frame_done, frame_err;
  logic [2:0] win_col;
  logic [2:0] win_row;
  int pass_cnt = 0, total = 0;
  bit m_act, m_flush, m_ov, m_err;
  int m_idx, m_wc, m_wr;
  bit last_ir, last_se;

  census_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .WIN(K)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
    .shift_en(shift_en), .fifo_clr(fifo_clr), .out_valid(out_valid), .out_ready(out_ready),
    .win_col(win_col), .win_row(win_row), .frame_done(frame_done), .frame_err(frame_err));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_clear();
    m_act = 0; m_flush = 0; m_ov = 0; m_err = 0; m_idx = 0; m_wc = 0; m_wr = 0;
  endtask

  // pixels are tracked by linear raster index; col/row are derived by div/mod
  task automatic step(input bit v, input bit s, input bit r);
    bit ir, se, acc, nf;
    int p;
    @(negedge clk);
    in_valid = v; in_sof = s; out_ready = r;
    #1;
    ir = !m_flush && (!m_ov || r);
    acc = v && ir;
    se = acc && (m_act || s);
    last_ir = in_ready; last_se = shift_en;
    chk("in_ready", in_ready, ir);
    chk("shift_en", shift_en, se);
    p = -1;
    m_err = acc && s && m_act;
    if (se) p = s ? 0 : m_idx;
    if (m_ov && r) m_ov = 0;
    if (p >= 0 && p % W >= K - 1 && p / W >= K - 1) begin
      m_ov = 1; m_wc = p % W; m_wr = p / W;
    end
    nf = (p == W * H - 1) && !s;
    if (p >= 0) begin m_act = !nf; m_idx = nf ? 0 : p + 1; end
    m_flush = nf;
    @(posedge clk); #1;
    chk("out_valid", out_valid, m_ov);
    chk("win_col", win_col, m_wc);
    chk("win_row", win_row, m_wr);
    chk("fifo_clr", fifo_clr, m_flush);
    chk("frame_done", frame_done, m_flush);
    chk("frame_err", frame_err, m_err);
  endtask

  task automatic areset();
    #2 rst = 0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_shift_en", shift_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fifo_clr", fifo_clr, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_win", {win_col, win_row}, 0);
    model_clear();
    @(negedge clk) rst = 1;
  endtask

  typedef struct {bit v, s, r, ir, se, ov;} vec_t;
  vec_t tbl[10];
  int nwin, fi, fc, fr;

  initial begin
    tbl[0] = '{1, 0, 1, 1, 0, 0};
    tbl[1] = '{1, 0, 1, 1, 0, 0};
    tbl[2] = '{0, 0, 1, 1, 0, 0};
    tbl[3] = '{1, 1, 1, 1, 1, 0};
    tbl[4] = '{1, 0, 1, 1, 1, 0};
    tbl[5] = '{0, 0, 0, 1, 0, 0};
    tbl[6] = '{1, 0, 0, 1, 1, 0};
    tbl[7] = '{1, 0, 1, 1, 1, 0};
    tbl[8] = '{0, 0, 1, 1, 0, 0};
    tbl[9] = '{1, 0, 1, 1, 1, 0};
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_pulses", {fifo_clr, frame_done, frame_err}, 0);
    chk("reset_win", {win_col, win_row}, 0);
    @(negedge clk) rst = 1;

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].r);
      chk("tbl_in_ready", last_ir, tbl[i].ir);
      chk("tbl_shift_en", last_se, tbl[i].se);
      chk("tbl_out_valid", out_valid, tbl[i].ov);
    end
    areset();

    nwin = 0; fi = -1; fc = 0; fr = 0;
    for (int i = 0; i < W * H; i++) begin
      step(1, i == 0, 1);
      if (out_valid) begin
        nwin++;
        if (fi < 0) begin fi = i; fc = win_col; fr = win_row; end
      end
    end
    chk("frame_windows", nwin, 24);
    chk("first_win_idx", fi, 2 * W + 2);
    chk("first_win_col", fc, 2);
    chk("first_win_row", fr, 2);
    chk("last_fifo_clr", fifo_clr, 1);
    chk("last_frame_done", frame_done, 1);
    chk("flush_in_ready", in_ready, 0);
    step(1, 0, 1);
    chk("after_flush_clr", fifo_clr, 0);
    step(1, 0, 1);
    chk("idle_no_shift", last_se, 0);

    for (int i = 0; i <= 3 * W + 4; i++) step(1, i == 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0);
      chk("stall_in_ready", last_ir, 0);
      chk("stall_shift_en", last_se, 0);
      chk("stall_win", {win_col, win_row}, {3'd4, 3'd3});
    end
    step(1, 0, 1);
    chk("release_in_ready", last_ir, 1);
    chk("release_shift_en", last_se, 1);
    areset();
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1);
      chk("post_rst_shift", last_se, 0);
      chk("post_rst_ov", out_valid, 0);
    end

    for (int i = 0; i <= 2 * W + 4; i++) step(1, i == 0, 1);
    step(1, 1, 1);
    chk("midframe_err", frame_err, 1);
    for (int i = 1; i < 2 * W + 2; i++) begin
      step(1, 0, 1);
      chk("restart_no_win", out_valid, 0);
    end
    step(1, 0, 1);
    chk("restart_first_win", {out_valid, win_col, win_row}, {1'b1, 3'd2, 3'd2});
    for (int i = 2 * W + 3; i < W * H + 1; i++) step(1, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      step($urandom % 4 != 0, m_act ? ($urandom % 100 == 0) : ($urandom % 4 == 0), $urandom % 3 != 0);
      if ($urandom % 600 == 0) areset();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
